// File: rtl/vdp_vram_ifce.sv
// vdp_vram_ifce -- CPU-side VRAM access port of the vdp99 VDP.
//
// Handles the mode0 data port and the address-setup half of the mode1
// two-write protocol. Owns the auto-incrementing VRAM address, the
// read-ahead buffer (dout), and the req/ack handshake to the VRAM arbiter.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   wr0_tick, rd0_tick  CPU write/read pulses on the mode0 (data) port
//   wr1_tick, rd1_tick  CPU write/read pulses on the mode1 (control/status) port
//   din                 CPU write data
//   dout                read-ahead buffer returned on mode0 reads
//   vram_req/we/addr/wdata  access request to the arbiter, held until vram_ack
//   vram_ack, vram_rdata    access completion and read data from the arbiter
//   busy                access outstanding or queued read-ahead
//   overrun             one-cycle pulse when a mode0 tick is dropped
module vdp_vram_ifce #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr0_tick,
    input  logic                  rd0_tick,
    input  logic                  wr1_tick,
    input  logic                  rd1_tick,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic                  vram_req,
    output logic                  vram_we,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [7:0]            vram_wdata,
    input  logic                  vram_ack,
    input  logic [7:0]            vram_rdata,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            w0;
    logic                  phase;
    logic                  pending_prefetch;
    // Set when the address was re-programmed under an in-flight access:
    // that access's ack must not bump the freshly loaded address.
    logic                  hold_addr;

    logic                  ack;
    logic                  idle;
    logic                  start_pend;
    logic                  start_wr;
    logic                  start_rd;
    logic                  starting;
    logic                  in_flight;
    logic                  setup;
    logic                  setup_rd;
    logic [13:0]           setup_raw;
    logic [ADDR_WIDTH-1:0] setup_addr;

    assign vram_req = (state != IDLE);
    assign vram_we  = (state == WRITE);
    assign busy     = vram_req | pending_prefetch;

    assign ack        = vram_ack & vram_req;
    assign idle       = (state == IDLE);
    assign start_pend = idle & pending_prefetch;
    assign start_wr   = idle & ~pending_prefetch & wr0_tick;
    assign start_rd   = idle & ~pending_prefetch & ~wr0_tick & rd0_tick;
    assign starting   = start_pend | start_wr | start_rd;
    // An access will still be outstanding after this edge.
    assign in_flight  = (vram_req & ~vram_ack) | starting;

    // Second control write with din[7]=0 programs the address (00 read, 01 write).
    assign setup      = wr1_tick & phase & ~din[7];
    assign setup_rd   = setup & ~din[6];
    assign setup_raw  = {din[5:0], w0};
    assign setup_addr = ADDR_WIDTH'(setup_raw);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            addr             <= '0;
            w0               <= '0;
            phase            <= 1'b0;
            dout             <= '0;
            vram_addr        <= '0;
            vram_wdata       <= '0;
            pending_prefetch <= 1'b0;
            hold_addr        <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            overrun <= (wr0_tick | rd0_tick) & busy;

            if (wr1_tick)
                phase <= ~phase;
            else if (rd1_tick | wr0_tick | rd0_tick)
                phase <= 1'b0;

            if (wr1_tick && !phase)
                w0 <= din;

            if (ack) begin
                state <= IDLE;
                if (state == READ)
                    dout <= vram_rdata;
                if (!hold_addr)
                    addr <= addr + ADDR_WIDTH'(1);
                hold_addr <= 1'b0;
            end

            if (start_pend) begin
                state            <= READ;
                vram_addr        <= addr;
                pending_prefetch <= 1'b0;
            end

            if (start_wr) begin
                state      <= WRITE;
                vram_addr  <= addr;
                vram_wdata <= din;
                dout       <= din;
            end

            if (start_rd) begin
                state     <= READ;
                vram_addr <= addr;
            end

            // Address setup comes last so it overrides the ack increment.
            if (setup) begin
                addr <= setup_addr;
                if (in_flight)
                    hold_addr <= 1'b1;
                if (!setup_rd)
                    pending_prefetch <= 1'b0;
                else if (in_flight || ack)
                    pending_prefetch <= 1'b1;   // fetch once the port frees up
                else begin
                    state     <= READ;          // port idle: fetch right away
                    vram_addr <= setup_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_vdp_vram_ifce.sv
module tb_vdp_vram_ifce;

    logic        clk;
    logic        reset;
    logic        wr0_tick, rd0_tick, wr1_tick, rd1_tick;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        vram_req, vram_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_ack;
    logic [7:0]  vram_rdata;
    logic        busy, overrun;

    vdp_vram_ifce #(.ADDR_WIDTH(14)) dut (
        .clk(clk), .reset(reset),
        .wr0_tick(wr0_tick), .rd0_tick(rd0_tick),
        .wr1_tick(wr1_tick), .rd1_tick(rd1_tick),
        .din(din), .dout(dout),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
        .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: CPU-visible state of the port.
    logic [13:0] m_addr;
    logic [7:0]  m_w0;
    logic [7:0]  m_dout;
    bit          m_phase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // All stimulus runs at posedge+1.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // 0 = wr0, 1 = rd0, 2 = wr1, 3 = rd1
    task automatic pulse(input int which, input logic [7:0] d);
        din = d;
        case (which)
            0: wr0_tick = 1'b1;
            1: rd0_tick = 1'b1;
            2: wr1_tick = 1'b1;
            default: rd1_tick = 1'b1;
        endcase
        cyc();
        wr0_tick = 1'b0; rd0_tick = 1'b0; wr1_tick = 1'b0; rd1_tick = 1'b0;
    endtask

    // Wait (bounded) for a request, check it, hold ack off for dly cycles, then ack.
    task automatic service(input bit we, input logic [13:0] a, input logic [7:0] wd,
                           input int dly, input logic [7:0] rd);
        int t = 0;
        while (!vram_req && t < 20) begin
            cyc();
            t++;
        end
        chk("req_seen", {31'd0, vram_req}, 1);
        if (!vram_req) return;
        chk("req_we", {31'd0, vram_we}, {31'd0, we});
        chk("req_addr", {18'd0, vram_addr}, {18'd0, a});
        if (we) chk("req_wdata", {24'd0, vram_wdata}, {24'd0, wd});
        for (int i = 0; i < dly; i++) begin
            cyc();
            chk("req_hold", {17'd0, vram_req, vram_addr}, {17'd0, 1'b1, a});
        end
        vram_ack = 1'b1;
        vram_rdata = rd;
        cyc();
        vram_ack = 1'b0;
        vram_rdata = 8'($urandom);
    endtask

    task automatic post_chk(input string tag);
        chk({tag, "_dout"}, {24'd0, dout}, {24'd0, m_dout});
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_req"}, {31'd0, vram_req}, 0);
    endtask

    task automatic op_wr0(input logic [7:0] d, input int dly);
        pulse(0, d);
        m_phase = 0;
        service(1'b1, m_addr, d, dly, 8'($urandom));
        m_dout = d;
        m_addr = m_addr + 14'd1;
        post_chk("wr0");
    endtask

    task automatic op_rd0(input logic [7:0] rd, input int dly);
        pulse(1, 8'h00);
        m_phase = 0;
        service(1'b0, m_addr, 8'h00, dly, rd);
        m_dout = rd;
        m_addr = m_addr + 14'd1;
        post_chk("rd0");
    endtask

    task automatic op_rd1();
        pulse(3, 8'h00);
        m_phase = 0;
        cyc();
        post_chk("rd1");
    endtask

    task automatic op_wr1(input logic [7:0] d, input logic [7:0] rd, input int dly);
        pulse(2, d);
        if (!m_phase) begin
            m_w0 = d;
            m_phase = 1;
            cyc();
            post_chk("wr1a");
        end else begin
            m_phase = 0;
            if (d[7:6] == 2'b00) begin
                m_addr = {d[5:0], m_w0};
                service(1'b0, m_addr, 8'h00, dly, rd);
                m_dout = rd;
                m_addr = m_addr + 14'd1;
                post_chk("setup_rd");
            end else begin
                if (d[7:6] == 2'b01) m_addr = {d[5:0], m_w0};
                cyc();
                post_chk("wr1b");
            end
        end
    endtask

    initial begin
        int ov;
        int sel;
        reset = 1'b1;
        wr0_tick = 0; rd0_tick = 0; wr1_tick = 0; rd1_tick = 0;
        din = 0; vram_ack = 0; vram_rdata = 0;
        m_addr = 0; m_w0 = 0; m_dout = 0; m_phase = 0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        chk("rst_req", {31'd0, vram_req}, 0);
        chk("rst_we", {31'd0, vram_we}, 0);
        chk("rst_dout", {24'd0, dout}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_overrun", {31'd0, overrun}, 0);
        chk("rst_wdata", {24'd0, vram_wdata}, 0);

        // Read setup to 0x1234, then data comes back as the read-ahead.
        op_wr1(8'h34, 8'h00, 0);
        op_wr1(8'h12, 8'hA5, 1);
        op_rd0(8'h3C, 0);                       // next access lands at 0x1235

        // Write setup to 0x3F00 and three streaming writes.
        op_wr1(8'h00, 8'h00, 0);
        op_wr1(8'h7F, 8'h00, 0);
        op_wr0(8'h11, 0);
        op_wr0(8'h22, 2);
        op_wr0(8'h33, 1);
        chk("stream_dout", {24'd0, dout}, 32'h33);

        // Wrap from the top of the address space.
        op_wr1(8'hFF, 8'h00, 0);
        op_wr1(8'h7F, 8'h00, 0);
        op_wr0(8'h55, 0);
        chk("wrap_model", {18'd0, m_addr}, 0);
        op_rd0(8'h9E, 3);

        // rd1 resets the phase, so the later 0x00 is a first write.
        op_wr1(8'h40, 8'h00, 0);
        op_rd1();
        op_wr1(8'h00, 8'h00, 0);
        repeat (3) begin
            cyc();
            chk("nophase_req", {31'd0, vram_req}, 0);
        end
        op_rd0(8'h47, 0);                       // address unchanged by that sequence

        // Tick while busy: dropped, overrun pulses once.
        pulse(0, 8'h66);
        m_phase = 0;
        chk("ovr_req", {31'd0, vram_req}, 1);
        chk("ovr_addr", {18'd0, vram_addr}, {18'd0, m_addr});
        pulse(0, 8'h77);
        ov = overrun ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (overrun) ov++;
        end
        chk("ovr_pulses", ov, 1);
        chk("ovr_wdata", {24'd0, vram_wdata}, 32'h66);
        vram_ack = 1'b1;
        cyc();
        vram_ack = 1'b0;
        m_dout = 8'h66;
        m_addr = m_addr + 14'd1;
        repeat (3) begin
            cyc();
            chk("ovr_no_second", {31'd0, vram_req}, 0);
        end
        post_chk("ovr");
        op_rd0(8'hD2, 1);

        // Read setup to 0x0100 while a write to 0x0200 is outstanding.
        op_wr1(8'h00, 8'h00, 0);
        op_wr1(8'h42, 8'h00, 0);
        pulse(0, 8'hAB);
        m_phase = 0;
        chk("ovl_waddr", {18'd0, vram_addr}, 32'h0200);
        pulse(2, 8'h00);
        pulse(2, 8'h01);
        chk("ovl_keep_addr", {18'd0, vram_addr}, 32'h0200);
        chk("ovl_keep_we", {31'd0, vram_we}, 1);
        chk("ovl_busy", {31'd0, busy}, 1);
        vram_ack = 1'b1;
        cyc();
        vram_ack = 1'b0;
        chk("ovl_busy_pend", {31'd0, busy}, 1);
        service(1'b0, 14'h0100, 8'h00, 1, 8'h5C);
        m_addr = 14'h0101;
        m_dout = 8'h5C;
        post_chk("ovl");
        op_rd0(8'h61, 0);                       // confirms final address 0x0101

        // Reset mid-access; the late ack must be ignored.
        pulse(0, 8'h99);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rstmid_req", {31'd0, vram_req}, 0);
        vram_ack = 1'b1;
        cyc();
        vram_ack = 1'b0;
        cyc();
        m_addr = 0; m_w0 = 0; m_dout = 0; m_phase = 0;
        post_chk("rstmid");
        op_rd0(8'h18, 0);

        // Randomized mix against the model.
        for (int n = 0; n < 200; n++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0, 1: op_wr1(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
                2:    op_wr0(8'($urandom), int'($urandom_range(0, 3)));
                3, 4: op_rd0(8'($urandom), int'($urandom_range(0, 3)));
                default: op_rd1();
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
